sr_cmd_sequencer: RTL and testbench

//   Command-driven controller for a bank of N SR flip-flops (the JK/D/T-built SR cells).

---
 rtl/sr_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a bank of SR cells: accepts SET/RESET/TOGGLE/NOP,
// pulses one cell's S or R, reads back Q and retries before reporting done/err.
module sr_cmd_sequencer #(
    parameter int N         = 4,
    parameter int ADDR_W    = 2,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [N-1:0]      S,
    output logic [N-1:0]      R,
    input  logic [N-1:0]      Q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [ADDR_W:0] N_LIM = (ADDR_W + 1)'(N);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              target_q, target_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [N-1:0]      s_d, r_d;
    logic              done_d, err_d, busy_d;
    logic              accept, addr_bad, q_cmd, q_held;
    logic [N-1:0]      cmd_onehot, held_onehot;

    assign cmd_ready   = (state == ST_IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign addr_bad    = {1'b0, cmd_addr} >= N_LIM;
    assign cmd_onehot  = N'(1) << cmd_addr;
    assign held_onehot = N'(1) << addr_q;
    assign q_cmd       = |(Q & cmd_onehot);
    assign q_held      = |(Q & held_onehot);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            S        <= '0;
            R        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            err_cnt  <= 8'd0;
            retry_q  <= '0;
            settle_q <= '0;
            addr_q   <= '0;
            target_q <= 1'b0;
        end else begin
            state    <= state_d;
            S        <= s_d;
            R        <= r_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            if (err_d && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // S/R are registered, so the drive pattern is produced on the transition into DRIVE.
    always_comb begin
        state_d  = state;
        addr_d   = addr_q;
        target_d = target_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        s_d      = '0;
        r_d      = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_NOP) begin
                        done_d = 1'b1;
                    end else if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        retry_d = '0;
                        case (cmd_op)
                            OP_SET:   target_d = 1'b1;
                            OP_RESET: target_d = 1'b0;
                            default:  target_d = ~q_cmd;
                        endcase
                        s_d     = target_d ? cmd_onehot : '0;
                        r_d     = target_d ? '0 : cmd_onehot;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (q_held == target_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    // Retries reuse the target latched at accept, even for TOGGLE.
                    retry_d = retry_q + 1'b1;
                    s_d     = target_q ? held_onehot : '0;
                    r_d     = target_q ? '0 : held_onehot;
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer: a behavioural SR bank with stuck-low
// injection feeds Q; expected completions are queued at issue and matched on done/err.
module tb_sr_cmd_sequencer;

    localparam int N_P         = 4;
    localparam int AW          = 2;
    localparam int SETTLE_P    = 1;
    localparam int MAX_RETRY_P = 2;
    localparam int LAT_OK      = 3 + SETTLE_P;
    localparam int RETRY_ADD   = 2 + SETTLE_P;

    typedef struct {
        string        tag;
        int           t;
        bit           is_err;
        int           lat;
        int           drives;
        logic [7:0]   sr;
        bit           chk_q;
        int           qidx;
        bit           qval;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, cmd_valid, cmd_ready, busy, done, err;
    logic [1:0]     cmd_op;
    logic [AW-1:0]  cmd_addr;
    logic [N_P-1:0] S, R, Q;
    logic [7:0]     err_cnt;

    logic           valid3, ready3, busy3, done3, err3;
    logic [1:0]     op3;
    logic [AW-1:0]  addr3;
    logic [2:0]     s3, r3, q3;
    logic [7:0]     err_cnt3;

    logic [N_P-1:0] bank_q   = '0;
    logic [N_P-1:0] stuck_lo = '0;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   drives = 0;
    int   exp_err_cnt = 0;
    bit   mon_en = 1'b0;
    logic [7:0] first_sr = '0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign Q  = bank_q & ~stuck_lo;
    assign q3 = 3'b000;

    sr_cmd_sequencer #(.N(N_P), .ADDR_W(AW), .SETTLE(SETTLE_P), .MAX_RETRY(MAX_RETRY_P)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .S(S), .R(R), .Q(Q),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    sr_cmd_sequencer #(.N(3), .ADDR_W(AW), .SETTLE(SETTLE_P), .MAX_RETRY(MAX_RETRY_P)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(valid3), .cmd_ready(ready3),
        .cmd_op(op3), .cmd_addr(addr3), .S(s3), .R(r3), .Q(q3),
        .busy(busy3), .done(done3), .err(err3), .err_cnt(err_cnt3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < N_P; i++) begin
            if (S[i]) bank_q[i] <= 1'b1;
            else if (R[i]) bank_q[i] <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle invariants plus scoreboard pop on every done/err pulse.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rst) begin
                drives      = 0;
                first_sr    = '0;
                exp_err_cnt = 0;
            end else begin
                checkOutput("s_and_r", 32'(S & R), 32'd0);
                checkOutput("sr_onehot", 32'($countones(S | R) <= 1), 32'd1);
                checkOutput("done_err_excl", 32'(done & err), 32'd0);
                checkOutput("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
                if (|(S | R)) begin
                    if (drives == 0) first_sr = {S, R};
                    drives++;
                end
                if (done || err) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out", 32'({done, err}), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.is_err) exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
                        checkOutput({mon_e.tag, "_kind"}, 32'({done, err}), mon_e.is_err ? 32'd1 : 32'd2);
                        checkOutput({mon_e.tag, "_lat"}, 32'(cyc - mon_e.t), 32'(mon_e.lat));
                        checkOutput({mon_e.tag, "_drives"}, 32'(drives), 32'(mon_e.drives));
                        checkOutput({mon_e.tag, "_first_sr"}, 32'(first_sr), 32'(mon_e.sr));
                        checkOutput({mon_e.tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err_cnt));
                        if (mon_e.chk_q) checkOutput({mon_e.tag, "_q"}, 32'(Q[mon_e.qidx]), 32'(mon_e.qval));
                    end
                    drives   = 0;
                    first_sr = '0;
                end
            end
        end
    end

    // Waits for ready, queues the expected completion and presents one command.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [AW-1:0] addr, output int t);
        exp_t           e;
        logic           tgt;
        logic [N_P-1:0] oh;
        int             n;
        t = -1;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        oh = '0;
        oh[addr] = 1'b1;
        tgt = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? 1'b0 : ~Q[addr];
        e.tag = tag;
        e.t = cyc;
        e.qidx = int'(addr);
        e.qval = tgt;
        if (op == 2'b00) begin
            e.is_err = 1'b0; e.lat = 1; e.drives = 0; e.sr = '0; e.chk_q = 1'b0;
        end else if (tgt && stuck_lo[addr]) begin
            e.is_err = 1'b1; e.lat = LAT_OK + MAX_RETRY_P * RETRY_ADD;
            e.drives = 1 + MAX_RETRY_P; e.sr = {oh, {N_P{1'b0}}}; e.chk_q = 1'b0;
        end else begin
            e.is_err = 1'b0; e.lat = LAT_OK; e.drives = 1; e.chk_q = 1'b1;
            e.sr = tgt ? {oh, {N_P{1'b0}}} : {{N_P{1'b0}}, oh};
        end
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = AW'($urandom_range(0, 3));
        t = e.t;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) checkOutput({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, t_tog;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 2'd2;
        valid3 = 1'b0; op3 = 2'b00; addr3 = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_S", 32'(S), 32'd0);
            checkOutput("rst_R", 32'(R), 32'd0);
            checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
            checkOutput("rst_errcnt", 32'(err_cnt), 32'd0);
        end
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Out-of-range address on a 3-cell instance.
        checkOutput("n3_ready", 32'(ready3), 32'd1);
        valid3 = 1'b1; op3 = 2'b01; addr3 = 2'd3;
        @(posedge clk);
        #1 valid3 = 1'b0;
        @(negedge clk);
        checkOutput("n3_err", 32'(err3), 32'd1);
        checkOutput("n3_done", 32'(done3), 32'd0);
        checkOutput("n3_sr", 32'({s3, r3}), 32'd0);
        checkOutput("n3_errcnt", 32'(err_cnt3), 32'd1);
        checkOutput("n3_busy", 32'(busy3), 32'd0);
        @(negedge clk);
        checkOutput("n3_err_pulse", 32'(err3), 32'd0);
        checkOutput("n3_sr_after", 32'({s3, r3}), 32'd0);

        applyStimulus("set2", 2'b01, 2'd2, t);
        applyStimulus("set1", 2'b01, 2'd1, t);
        applyStimulus("tog1", 2'b11, 2'd1, t_tog);
        applyStimulus("reset1_b2b", 2'b10, 2'd1, t);
        checkOutput("b2b_accept", 32'(t), 32'(t_tog + LAT_OK));
        applyStimulus("nop", 2'b00, 2'd3, t);
        waitIdle("nop");

        stuck_lo = 4'b0001;
        applyStimulus("stuck0", 2'b01, 2'd0, t);
        waitIdle("stuck0");
        stuck_lo = '0;

        // Reset lands while a SET is in its settle window.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 2'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_drive_S", 32'(S), 32'h8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_S", 32'(S), 32'd0);
        checkOutput("abort_R", 32'(R), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(cmd_ready), 32'd0);
        checkOutput("abort_errcnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("abort_quiet", 32'({done, err}), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus("rand", 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), t);
        end
        waitIdle("final");
        checkOutput("final_drain", 32'(sb.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
